// File: rtl/scr1_ahb_mstr_pkg.sv
// Shared definitions for the SCR1 AHB-Lite master bridge: AHB encodings and the pipeline stage payload.
package scr1_ahb_mstr_pkg;

  localparam int unsigned SCR1_AHB_WIDTH = 32;
  localparam int unsigned SCR1_AHB_MSTR_ERR_CNT_W = 16;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
  localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
  localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

  localparam logic [2:0] SCR1_HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic                      vld;
    logic                      cmd;
    logic [1:0]                width;
    logic [SCR1_AHB_WIDTH-1:0] addr;
    logic [SCR1_AHB_WIDTH-1:0] wdata;
  } scr1_ahb_mstr_stage_t;

  // Reset payload leaves HSIZE at word so the idle bus shows 3'b010
  localparam scr1_ahb_mstr_stage_t SCR1_AHB_MSTR_STAGE_RST = '{
    vld:   1'b0,
    cmd:   1'b0,
    width: SCR1_HSIZE_32B[1:0],
    addr:  '0,
    wdata: '0
  };

endpackage : scr1_ahb_mstr_pkg

// File: rtl/scr1_ahb_mstr_stage.sv
// Loadable pipeline register with valid flag; load wins over clear.
module scr1_ahb_mstr_stage
  import scr1_ahb_mstr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld,
  input  logic                 clr,
  input  scr1_ahb_mstr_stage_t d,
  output scr1_ahb_mstr_stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SCR1_AHB_MSTR_STAGE_RST;
    end else if (ld) begin
      q <= d;
    end else if (clr) begin
      q.vld <= 1'b0;
    end
  end

endmodule : scr1_ahb_mstr_stage

// File: rtl/scr1_ahb_mstr_bridge.sv
// Two-stage (address/data phase) AHB-Lite master bridge for a simple req/resp requester.
// Optional error counter output err_cnt is built when SCR1_AHB_MSTR_ERR_CNT_EN is defined.
module scr1_ahb_mstr_bridge
  import scr1_ahb_mstr_pkg::*;
#(
  parameter logic [3:0] SCR1_AHB_MSTR_HPROT = 4'b0011
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req,
  output logic                               req_ack,
  input  logic                               req_cmd,
  input  logic [1:0]                         req_width,
  input  logic [SCR1_AHB_WIDTH-1:0]          req_addr,
  input  logic [SCR1_AHB_WIDTH-1:0]          req_wdata,
  output logic                               resp,
  output logic                               resp_err,
  output logic [SCR1_AHB_WIDTH-1:0]          resp_rdata,
`ifdef SCR1_AHB_MSTR_ERR_CNT_EN
  output logic [SCR1_AHB_MSTR_ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [3:0]                         hprot,
  output logic [2:0]                         hburst,
  output logic [2:0]                         hsize,
  output logic [1:0]                         htrans,
  output logic                               hmastlock,
  output logic [SCR1_AHB_WIDTH-1:0]          haddr,
  output logic                               hwrite,
  output logic [SCR1_AHB_WIDTH-1:0]          hwdata,
  input  logic                               hready,
  input  logic [SCR1_AHB_WIDTH-1:0]          hrdata,
  input  logic                               hresp
);

  scr1_ahb_mstr_stage_t addr_d;
  scr1_ahb_mstr_stage_t addr_q;
  scr1_ahb_mstr_stage_t data_q;
  logic                 addr_adv;
  logic                 data_done;
  logic                 data_unused;

  // Address phase advances and data phase completes on the same hready
  assign addr_adv  = addr_q.vld & hready;
  assign data_done = data_q.vld & hready;
  assign req_ack   = rst_n & req & (~addr_q.vld | hready);

  assign addr_d = '{
    vld:   1'b1,
    cmd:   req_cmd,
    width: req_width,
    addr:  req_addr,
    wdata: req_wdata
  };

  scr1_ahb_mstr_stage u_addr_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (req_ack),
    .clr   (addr_adv),
    .d     (addr_d),
    .q     (addr_q)
  );

  scr1_ahb_mstr_stage u_data_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (addr_adv),
    .clr   (data_done),
    .d     (addr_q),
    .q     (data_q)
  );

  // The data stage only needs cmd and wdata; address and width ride along unused
  assign data_unused = ^{data_q.width, data_q.addr};

  assign htrans    = addr_q.vld ? SCR1_HTRANS_NONSEQ : SCR1_HTRANS_IDLE;
  assign haddr     = addr_q.addr;
  assign hwrite    = addr_q.cmd;
  assign hsize     = {1'b0, addr_q.width};
  assign hwdata    = data_q.wdata;
  assign hburst    = SCR1_HBURST_SINGLE;
  assign hmastlock = 1'b0;
  assign hprot     = SCR1_AHB_MSTR_HPROT;

  assign resp       = rst_n & data_done;
  assign resp_err   = resp & hresp;
  assign resp_rdata = (resp & ~data_q.cmd) ? hrdata : '0;

`ifdef SCR1_AHB_MSTR_ERR_CNT_EN
  logic [SCR1_AHB_MSTR_ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of error responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (resp_err && (err_cnt_q != {SCR1_AHB_MSTR_ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + SCR1_AHB_MSTR_ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule : scr1_ahb_mstr_bridge

// File: doc/scr1_ahb_mstr_bridge.md
SCR1_AHB_MSTR_BRIDGE -- requirements
Module: scr1_ahb_mstr_bridge

Interface
REQ-001 SHALL have parameter SCR1_AHB_MSTR_HPROT, default 4'b0011, constant HPROT driven on every transfer.
REQ-002 SHALL have port clk  input  1  core clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req  input  1  requester transfer request.
REQ-005 SHALL have port req_ack  output  1  request accepted this cycle.
REQ-006 SHALL have port req_cmd  input  1  0 read, 1 write.
REQ-007 SHALL have port req_width  input  2  0 byte, 1 halfword, 2 word.
REQ-008 SHALL have port req_addr  input  32  byte address, naturally aligned to req_width.
REQ-009 SHALL have port req_wdata  input  32  write data, already lane-aligned.
REQ-010 SHALL have port resp  output  1  one-cycle response strobe.
REQ-011 SHALL have port resp_err  output  1  response carried HRESP ERROR.
REQ-012 SHALL have port resp_rdata  output  32  read data, valid with resp for reads.
REQ-013 SHALL have ports hprot (4), hburst (3), hsize (3), htrans (2), hmastlock (1), haddr (32), hwrite (1), hwdata (32) as outputs, and hready (1), hrdata (32), hresp (1) as inputs, all AHB-Lite master signals.

Function
REQ-014 SHALL hold an address-phase stage and a data-phase stage, each with a valid flag.
REQ-015 SHALL assert req_ack = req & (!addr_vld | hready), combinationally.
REQ-016 SHALL load the address stage on req_ack and drive htrans NONSEQ, haddr, hwrite and hsize = {1'b0,req_width} from the next cycle.
REQ-017 SHALL drive htrans IDLE whenever addr_vld=0, and SHALL keep haddr, hwrite and hsize stable while NONSEQ and hready=0.
REQ-018 SHALL move the address stage to the data stage on hready=1 with addr_vld=1, and SHALL drive hwdata from the data stage for the whole data phase.
REQ-019 SHALL pulse resp for one cycle when data_vld=1 and hready=1, with resp_err=hresp and resp_rdata=hrdata.
REQ-020 SHALL reach latency request-to-resp of 2 cycles at zero wait states, with one transfer per cycle sustained (back-to-back NONSEQ).
REQ-021 SHALL return responses strictly in request order.
REQ-022 SHALL not cancel the pending address phase on an error response; the first error cycle (hresp=1, hready=0) is a plain wait state.
REQ-023 SHALL tie hburst to SINGLE, hmastlock to 0 and hprot to SCR1_AHB_MSTR_HPROT.
REQ-024 SHALL, on simultaneous data-phase completion and new acceptance, retire the old transfer and load the new one in the same cycle.
REQ-025 SHALL keep resp_rdata equal to 0 on write responses.

Reset
REQ-026 SHALL on rst_n=0 clear addr_vld and data_vld and force htrans IDLE, haddr 0, hwrite 0, hsize 3'b010, hwdata 0, req_ack 0, resp 0, resp_err 0 and resp_rdata 0.
REQ-027 SHALL, when reset is asserted mid-transfer, drop in-flight transfers with no resp generated.

Configuration
REQ-028 SHALL compile an error counter when macro SCR1_AHB_MSTR_ERR_CNT_EN is defined: output err_cnt (16 bits), incremented on each resp with resp_err=1, saturating at 16'hFFFF, and reset to 0.
REQ-029 SHALL, without SCR1_AHB_MSTR_ERR_CNT_EN, have no err_cnt port and no counter logic.

Structure
REQ-030 SHALL take HTRANS, HSIZE and HBURST encodings and SCR1_AHB_WIDTH from the shared scr1_ahb.svh, and SHALL define the stage typedef (vld, cmd, width, addr, wdata) in a shared package scr1_ahb_mstr_pkg.
REQ-031 SHALL use one sub-module, scr1_ahb_mstr_stage, a loadable pipeline register with valid used for both stages.

Verification
REQ-032 SHALL cover a word read to 0x100 with hready always 1 and hrdata=0xDEADBEEF -> NONSEQ one cycle after req_ack, resp two cycles after req_ack, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-033 SHALL cover four back-to-back byte writes to 0x0..0x3 with zero wait states -> four consecutive NONSEQ cycles with hsize=0, hwdata lagging haddr by one cycle, and four resp pulses in order.
REQ-034 SHALL cover a word read held with hready=0 for 3 cycles while a second req is pending -> req_ack held 0, haddr/htrans stable, resp on the first hready=1 cycle.
REQ-035 SHALL cover an error response (hresp=1 for two cycles, hready 0 then 1) -> exactly one resp with resp_err=1, the next transfer still issued, and err_cnt=1 when SCR1_AHB_MSTR_ERR_CNT_EN is defined.
REQ-036 SHALL cover rst_n asserted during a data phase -> htrans IDLE immediately, no resp, and the next request after release completing normally.
REQ-037 SHALL cover random req and hready stall patterns of 0-7 cycles against an AHB responder model -> data matches a scoreboard and AHB-Lite stability assertions pass.
